writeback_unit: RTL
===================

Name: writeback_unit

Overview:
Writeback stage of the five-stage RISC-V pipeline. It is the writer side of the register file. It accepts retiring instructions from the MEM stage over a valid/ready handshake and selects the result: ALU result, formatted load data, or PC+4. It waits for late load responses, then drives the register file write port as a registered one-cycle pulse. It also reports pending load destinations to the hazard unit and counts retired instructions.

Parameters:
XLEN, 32, datapath width (only 32 supported)
CNT_W, 64, retire counter width

Ports:
clock  input  1  pipeline clock, rising edge
reset_n  input  1  asynchronous, active-low reset
wb_valid  input  1  MEM stage presents an instruction
wb_ready  output  1  unit can accept; combinational, high iff state==IDLE
wb_rd  input  5  destination register
wb_reg_write  input  1  instruction writes rd
wb_sel  input  2  00 ALU, 01 LOAD, 10 PC+4, 11 reserved
wb_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
wb_byte_off  input  2  load address bits [1:0]
wb_alu_result  input  32  ALU result
wb_pc  input  32  instruction PC
mem_rsp_valid  input  1  load data valid this cycle
mem_rsp_data  input  32  raw aligned memory word
rf_addr_rd  output  5  register file write address
rf_data_rd  output  32  register file write data
rf_write_enable  output  1  register file write strobe
fwd_pending  output  1  a load destination is outstanding
fwd_pending_rd  output  5  rd of the outstanding load
retire_count  output  CNT_W  retired instruction count
load_err  output  1  sticky: misaligned or illegal load seen

Behaviour:
- Reset (async assert, sync-released internally):
  - All outputs go to 0, except wb_ready=1.
  - State goes to IDLE. Any held instruction is discarded: no write, no count.
- States: IDLE, LOAD_WAIT.
- Handshake: an instruction is accepted on a rising edge where wb_valid && wb_ready.
- IDLE, accepted, wb_sel!=LOAD: completes on that edge.
- IDLE, accepted, LOAD with mem_rsp_valid=1 in the same cycle: completes on that edge.
- IDLE, accepted, LOAD with mem_rsp_valid=0:
  - Capture rd, reg_write, funct3 and byte_off into holding registers.
  - Go to LOAD_WAIT.
- LOAD_WAIT:
  - wb_ready=0.
  - fwd_pending=1 and fwd_pending_rd=held rd, only if held reg_write=1 and rd!=0.
  - On an edge with mem_rsp_valid=1: complete using the held fields, return to IDLE.
- mem_rsp_valid in IDLE without an accompanying load accept is ignored.
- Completion edge:
  - rf_addr_rd and rf_data_rd are registered.
  - rf_write_enable=1 for exactly the next cycle, iff reg_write && rd!=0 && wb_sel!=11 && no load error.
  - retire_count increments on every completion, including suppressed writes. It wraps from all-ones to 0.
  - Latency: accept (or response) edge → write strobe visible in the following cycle.
- After a strobe, rf_write_enable returns to 0. rf_addr_rd and rf_data_rd hold their last values.
- Result select:
  - ALU: wb_alu_result.
  - PC+4: wb_pc+4, modulo 2^32.
  - LOAD: extracted from mem_rsp_data.
- Load extraction:
  - LB/LBU: byte at bit offset byte_off*8, sign- or zero-extended.
  - LH/LHU: require byte_off[0]=0; halfword at bits [31:16] if byte_off[1], else [15:0]; sign- or zero-extended.
  - LW: requires byte_off=00.
  - funct3 011, 110, 111 are illegal.
  - Misaligned or illegal load: write suppressed, load_err set to 1. load_err clears only on reset.
- Back-to-back: in IDLE a new instruction can be accepted every cycle, giving one strobe per cycle.

Test Plan:
- ALU write: accept rd=5, sel=00, alu=0x12345678, reg_write=1 → next cycle rf_write_enable=1, rf_addr_rd=5, rf_data_rd=0x12345678; retire_count=1; the cycle after, enable=0.
- Load formatting, mem_rsp_data=0x80FF0000 with same-cycle response:
  - LB off=3 → 0xFFFFFF80.
  - LBU off=3 → 0x00000080.
  - LH off=2 → 0xFFFF80FF.
  - LHU off=2 → 0x000080FF.
  - LW off=0 → 0x80FF0000.
- Late load: LW rd=7 accepted, mem_rsp_valid rises 3 cycles later →
  - wb_ready=0 and fwd_pending=1, fwd_pending_rd=7 during the wait.
  - Write to x7 in the cycle after the response.
  - wb_ready=1 again.
- Suppression:
  - rd=0 with reg_write=1, and separately rd=9 with reg_write=0 → no strobe; retire_count +1 each.
  - LH off=1 → no strobe, load_err=1, and it stays 1 across 10 further instructions.
- PC+4 wrap: sel=10, pc=0xFFFFFFFC, rd=1 → rf_data_rd=0x00000000 with strobe.
- Reset mid-wait: assert reset_n=0 in LOAD_WAIT → wb_ready=1, fwd_pending=0, retire_count=0, rf_write_enable=0; a subsequent mem_rsp_valid causes no write.

Source files
------------

// File: rtl/writeback_unit.sv
// Writeback stage: selects ALU / formatted load / PC+4 and drives a registered one-cycle RF write strobe.
// Latency 1 cycle from accept (or late load response) edge; wb_ready drops while a load response is awaited.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wb_valid,
    output logic             wb_ready,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic [1:0]       wb_sel,
    input  logic [2:0]       wb_funct3,
    input  logic [1:0]       wb_byte_off,
    input  logic [XLEN-1:0]  wb_alu_result,
    input  logic [XLEN-1:0]  wb_pc,
    input  logic             mem_rsp_valid,
    input  logic [XLEN-1:0]  mem_rsp_data,
    output logic [4:0]       rf_addr_rd,
    output logic [XLEN-1:0]  rf_data_rd,
    output logic             rf_write_enable,
    output logic             fwd_pending,
    output logic [4:0]       fwd_pending_rd,
    output logic [CNT_W-1:0] retire_count,
    output logic             load_err
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    // Reset asserts asynchronously but releases two clocks after reset_n rises.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_int_n = rst_sync_q[1];

    state_t            state_q;
    logic [4:0]        hold_rd_q;
    logic              hold_rw_q;
    logic [2:0]        hold_f3_q;
    logic [1:0]        hold_off_q;
    logic [4:0]        rf_addr_q;
    logic [XLEN-1:0]   rf_data_q;
    logic              rf_we_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              load_err_q;

    logic [4:0]        cur_rd;
    logic              cur_rw;
    logic [1:0]        cur_sel;
    logic [2:0]        cur_f3;
    logic [1:0]        cur_off;
    logic              complete;
    logic              go_wait;
    logic [7:0]        byte_v;
    logic [15:0]       half_v;
    logic [XLEN-1:0]   ld_val;
    logic              ld_bad;
    logic              bad_load;
    logic [XLEN-1:0]   result_d;
    logic              we_d;

    assign wb_ready = (state_q == IDLE);

    always_comb begin
        cur_rd   = wb_rd;
        cur_rw   = wb_reg_write;
        cur_sel  = wb_sel;
        cur_f3   = wb_funct3;
        cur_off  = wb_byte_off;
        complete = 1'b0;
        go_wait  = 1'b0;
        if (state_q == LOAD_WAIT) begin
            cur_rd   = hold_rd_q;
            cur_rw   = hold_rw_q;
            cur_sel  = SEL_LOAD;
            cur_f3   = hold_f3_q;
            cur_off  = hold_off_q;
            complete = mem_rsp_valid;
        end else if (wb_valid) begin
            if (wb_sel == SEL_LOAD && !mem_rsp_valid) begin
                go_wait = 1'b1;
            end else begin
                complete = 1'b1;
            end
        end
    end

    always_comb begin
        byte_v = mem_rsp_data[{cur_off, 3'b000} +: 8];
        half_v = cur_off[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
        ld_val = '0;
        ld_bad = 1'b0;
        case (cur_f3)
            3'b000:  ld_val = {{(XLEN-8){byte_v[7]}}, byte_v};
            3'b100:  ld_val = {{(XLEN-8){1'b0}}, byte_v};
            3'b001: begin
                ld_val = {{(XLEN-16){half_v[15]}}, half_v};
                ld_bad = cur_off[0];
            end
            3'b101: begin
                ld_val = {{(XLEN-16){1'b0}}, half_v};
                ld_bad = cur_off[0];
            end
            3'b010: begin
                ld_val = mem_rsp_data;
                ld_bad = (cur_off != 2'b00);
            end
            default: ld_bad = 1'b1;
        endcase
        bad_load = (cur_sel == SEL_LOAD) && ld_bad;

        case (cur_sel)
            SEL_ALU:  result_d = wb_alu_result;
            SEL_LOAD: result_d = ld_val;
            SEL_PC4:  result_d = wb_pc + XLEN'(4);
            default:  result_d = '0;
        endcase
        we_d = cur_rw && (cur_rd != 5'd0) && (cur_sel != 2'b11) && !bad_load;
    end

    always_ff @(posedge clock or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q    <= IDLE;
            hold_rd_q  <= '0;
            hold_rw_q  <= 1'b0;
            hold_f3_q  <= '0;
            hold_off_q <= '0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            rf_we_q    <= 1'b0;
            cnt_q      <= '0;
            load_err_q <= 1'b0;
        end else begin
            rf_we_q <= 1'b0;
            if (complete) begin
                rf_addr_q <= cur_rd;
                rf_data_q <= result_d;
                rf_we_q   <= we_d;
                cnt_q     <= cnt_q + 1'b1;
                if (bad_load) begin
                    load_err_q <= 1'b1;
                end
                state_q <= IDLE;
            end else if (go_wait) begin
                hold_rd_q  <= wb_rd;
                hold_rw_q  <= wb_reg_write;
                hold_f3_q  <= wb_funct3;
                hold_off_q <= wb_byte_off;
                state_q    <= LOAD_WAIT;
            end
        end
    end

    assign rf_addr_rd      = rf_addr_q;
    assign rf_data_rd      = rf_data_q;
    assign rf_write_enable = rf_we_q;
    assign retire_count    = cnt_q;
    assign load_err        = load_err_q;
    assign fwd_pending     = (state_q == LOAD_WAIT) && hold_rw_q && (hold_rd_q != 5'd0);
    assign fwd_pending_rd  = fwd_pending ? hold_rd_q : 5'd0;

endmodule
